// File: rtl/servo_pwm_multi_if.sv
// Servo PWM bus: angle load strobes and enables in, pulses and status out.
interface servo_pwm_multi_if #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ANGLE_W = 8
);
    logic [N_CH*ANGLE_W-1:0] angle;
    logic [N_CH-1:0]         angle_valid;
    logic [N_CH-1:0]         ch_en;
    logic [N_CH-1:0]         pwm;
    logic                    frame_start;
    logic [N_CH-1:0]         settled;

    modport master (
        output angle, angle_valid, ch_en,
        input  pwm, frame_start, settled
    );

    modport slave (
        input  angle, angle_valid, ch_en,
        output pwm, frame_start, settled
    );
endinterface

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator sharing one frame counter. Each channel maps
// an angle code to a clamped pulse width; the active width only changes at
// frame boundaries and moves at most STEP_MAX per frame (0 = no limit).
module servo_pwm_multi #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned ANGLE_W      = 8,
    parameter int unsigned CNT_W        = 28,
    parameter int unsigned PERIOD_TICKS = 2000000,
    parameter int unsigned MIN_PULSE    = 50000,
    parameter int unsigned MAX_PULSE    = 250000,
    parameter int unsigned SCALE        = 784,
    parameter int unsigned CENTER_PULSE = 150000,
    parameter int unsigned STEP_MAX     = 20000
) (
    input  logic              clk,
    input  logic              rst,
    servo_pwm_multi_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] SCALE_C   = CNT_W'(SCALE);
    localparam logic [CNT_W-1:0] CENTER_C  = CNT_W'(CENTER_PULSE);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP_MAX);

    // Parameter sanity: pulse ordering, counter range, and mapping headroom.
    if (!(MIN_PULSE <= CENTER_PULSE && CENTER_PULSE <= MAX_PULSE &&
          MAX_PULSE < PERIOD_TICKS)) begin : g_bad_pulse_range
        $error("servo_pwm_multi: need MIN_PULSE <= CENTER_PULSE <= MAX_PULSE < PERIOD_TICKS");
    end
    if (longint'(PERIOD_TICKS) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("servo_pwm_multi: PERIOD_TICKS does not fit in CNT_W bits");
    end
    if ((longint'(MIN_PULSE) + ((longint'(1) << ANGLE_W) - 1) * longint'(SCALE))
        >= (longint'(1) << CNT_W)) begin : g_bad_map_w
        $error("servo_pwm_multi: angle mapping overflows CNT_W bits");
    end

    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic [CNT_W-1:0] cur      [N_CH];
    logic [CNT_W-1:0] tgt      [N_CH];
    logic [CNT_W-1:0] mapped   [N_CH];
    logic [CNT_W-1:0] cur_next [N_CH];
    logic [N_CH-1:0]  pwm_q;
    logic [N_CH-1:0]  settled_q;
    logic             frame_start_q;

    assign frame_end       = (cnt == LAST_TICK);
    assign bus.pwm         = pwm_q;
    assign bus.settled     = settled_q;
    assign bus.frame_start = frame_start_q;

    // Shared frame counter; frame_start lines up with cnt==0 being visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt           <= frame_end ? '0 : cnt + CNT_W'(1);
            frame_start_q <= frame_end;
        end
    end

    // Angle code to pulse width, clamped to the safe maximum.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            mapped[i] = MIN_C + CNT_W'(bus.angle[i*ANGLE_W +: ANGLE_W]) * SCALE_C;
            if (mapped[i] > MAX_C) begin
                mapped[i] = MAX_C;
            end
        end
    end

    // Slew-limited step of the active width toward the target.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            cur_next[i] = tgt[i];
            if (STEP_MAX != 0) begin
                if (tgt[i] > cur[i]) begin
                    if (tgt[i] - cur[i] > STEP_C) begin
                        cur_next[i] = cur[i] + STEP_C;
                    end
                end else if (cur[i] - tgt[i] > STEP_C) begin
                    cur_next[i] = cur[i] - STEP_C;
                end
            end
        end
    end

    // Per-channel target capture, boundary update, pulse and settled flags.
    // A strobe on the boundary edge lands in tgt while cur uses the old tgt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cur[i] <= CENTER_C;
                tgt[i] <= CENTER_C;
            end
            pwm_q     <= '0;
            settled_q <= '1;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (bus.angle_valid[i]) begin
                    tgt[i] <= mapped[i];
                end
                if (frame_end) begin
                    cur[i] <= cur_next[i];
                end
                pwm_q[i]     <= bus.ch_en[i] & (cnt < cur[i]);
                settled_q[i] <= (cur[i] == tgt[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with shortened frames. A second instance
// with the slew limit disabled sees the same inputs.
module tb_servo_pwm_multi;

    localparam int P      = 300;
    localparam int MINP   = 5;
    localparam int MAXP   = 250;
    localparam int CENTER = 100;

    typedef struct {
        int         cyc;
        logic [1:0] valid;
        logic [7:0] a0;
        logic [7:0] a1;
    } strobe_t;

    typedef struct {
        strobe_t    s1;
        strobe_t    s2;
        int         h0;
        int         h1;
        logic [1:0] set;
        int         h0_ns;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    servo_pwm_multi_if #(.N_CH(2), .ANGLE_W(8)) bus ();
    servo_pwm_multi_if #(.N_CH(2), .ANGLE_W(8)) bus_ns ();

    assign bus_ns.angle       = bus.angle;
    assign bus_ns.angle_valid = bus.angle_valid;
    assign bus_ns.ch_en       = bus.ch_en;

    servo_pwm_multi #(
        .N_CH(2), .ANGLE_W(8), .CNT_W(12), .PERIOD_TICKS(P),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .SCALE(1),
        .CENTER_PULSE(CENTER), .STEP_MAX(40)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    servo_pwm_multi #(
        .N_CH(2), .ANGLE_W(8), .CNT_W(12), .PERIOD_TICKS(P),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .SCALE(1),
        .CENTER_PULSE(CENTER), .STEP_MAX(0)
    ) dut_ns (
        .clk(clk), .rst(rst), .bus(bus_ns)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] trace [P];
    int         h0, h1, h0n;
    logic [1:0] set_end;
    bit         fs_ok;
    vec_t       tbl [19];
    strobe_t    n;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic strobe_t st(input int c, input logic [1:0] v, input int a0, input int a1);
        strobe_t s;
        s.cyc   = c;
        s.valid = v;
        s.a0    = 8'(a0);
        s.a1    = 8'(a1);
        return s;
    endfunction

    // One frame sampled on falling edges; sample k sees cnt==k.
    task automatic run_frame(input strobe_t s1, input strobe_t s2,
                             input int off_k, input int on_k, input bit fs0);
        h0 = 0; h1 = 0; h0n = 0; fs_ok = 1'b1;
        for (int k = 0; k < P; k++) begin
            trace[k] = bus.pwm;
            h0  += int'(bus.pwm[0]);
            h1  += int'(bus.pwm[1]);
            h0n += int'(bus_ns.pwm[0]);
            if (k == 0 && bus.frame_start !== fs0) fs_ok = 1'b0;
            if (k > 0 && bus.frame_start !== 1'b0) fs_ok = 1'b0;
            if (k == P-1) set_end = bus.settled;
            bus.angle_valid = '0;
            if (s1.cyc == k) begin
                bus.angle_valid = s1.valid;
                bus.angle = {s1.a1, s1.a0};
            end
            if (s2.cyc == k) begin
                bus.angle_valid = s2.valid;
                bus.angle = {s2.a1, s2.a0};
            end
            if (k == off_k) bus.ch_en[0] = 1'b0;
            if (k == on_k)  bus.ch_en[0] = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        n = st(-1, 2'b00, 0, 0);
        //          strobe 1                   strobe 2                 h0   h1   settled ns_h0
        tbl[0]  = '{n,                         n,                        100, 100, 2'b11, 100};
        tbl[1]  = '{st(50, 2'b01, 0, 0),       n,                        100, 100, 2'b10, 100};
        tbl[2]  = '{n,                         n,                         60, 100, 2'b10,   5};
        tbl[3]  = '{st(50, 2'b10, 0, 255),     n,                         20, 100, 2'b00,   5};
        tbl[4]  = '{n,                         n,                          5, 140, 2'b01,   5};
        tbl[5]  = '{n,                         n,                          5, 180, 2'b01,   5};
        tbl[6]  = '{n,                         n,                          5, 220, 2'b01,   5};
        tbl[7]  = '{n,                         n,                          5, 250, 2'b11,   5};
        tbl[8]  = '{st(50, 2'b01, 10, 0),      st(60, 2'b01, 200, 0),      5, 250, 2'b10,   5};
        tbl[9]  = '{n,                         n,                         45, 250, 2'b10, 205};
        tbl[10] = '{n,                         n,                         85, 250, 2'b10, 205};
        tbl[11] = '{n,                         n,                        125, 250, 2'b10, 205};
        tbl[12] = '{n,                         n,                        165, 250, 2'b10, 205};
        tbl[13] = '{n,                         n,                        205, 250, 2'b11, 205};
        tbl[14] = '{st(P-1, 2'b01, 100, 0),    n,                        205, 250, 2'b11, 205};
        tbl[15] = '{n,                         n,                        205, 250, 2'b10, 205};
        tbl[16] = '{n,                         n,                        165, 250, 2'b10, 105};
        tbl[17] = '{n,                         n,                        125, 250, 2'b10, 105};
        tbl[18] = '{n,                         n,                        105, 250, 2'b11, 105};

        bus.angle       = '0;
        bus.angle_valid = '0;
        bus.ch_en       = 2'b11;

        repeat (3) @(negedge clk);
        chk("reset_pwm", bus.pwm, 0);
        chk("reset_frame_start", bus.frame_start, 0);
        chk("reset_settled", bus.settled, 3);

        // First frame after release: centre pulse, no frame_start until cnt wraps.
        rst = 1'b1;
        run_frame(n, n, -1, -1, 1'b0);
        chk("first_h0", h0, CENTER);
        chk("first_h1", h1, CENTER);
        chk("first_fs", fs_ok, 1);
        chk("first_settled", set_end, 3);

        for (int i = 0; i < 19; i++) begin
            run_frame(tbl[i].s1, tbl[i].s2, -1, -1, 1'b1);
            chk($sformatf("v%0d_h0", i), h0, tbl[i].h0);
            chk($sformatf("v%0d_h1", i), h1, tbl[i].h1);
            chk($sformatf("v%0d_settled", i), set_end, tbl[i].set);
            chk($sformatf("v%0d_ns_h0", i), h0n, tbl[i].h0_ns);
            chk($sformatf("v%0d_frame_start", i), fs_ok, 1);
        end

        // Enable dropped at cnt 20, restored at cnt 30 while cur0=105.
        run_frame(n, n, 20, 30, 1'b1);
        chk("en_before_drop", trace[20][0], 1);
        chk("en_dropped_ch0", trace[21][0], 0);
        chk("en_dropped_ch1", trace[21][1], 1);
        chk("en_resumed_ch0", trace[31][0], 1);
        chk("en_h0", h0, 95);
        chk("en_h1", h1, 250);

        // Start a slew on ch1 (250 -> 5), then reset mid-pulse in the next frame.
        run_frame(st(50, 2'b10, 0, 0), n, -1, -1, 1'b1);
        chk("pre_rst_h0", h0, 105);
        chk("pre_rst_h1", h1, 250);
        repeat (60) @(negedge clk);
        chk("mid_pulse_pwm", bus.pwm, 3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pwm", bus.pwm, 0);
        chk("async_rst_ns_pwm", bus_ns.pwm, 0);
        chk("async_rst_frame_start", bus.frame_start, 0);
        chk("async_rst_settled", bus.settled, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_frame(n, n, -1, -1, 1'b0);
        chk("post_rst_h0", h0, CENTER);
        chk("post_rst_h1", h1, CENTER);
        chk("post_rst_ns_h0", h0n, CENTER);
        chk("post_rst_fs", fs_ok, 1);
        chk("post_rst_settled", set_end, 3);
        chk("post_rst_wrap_fs", bus.frame_start, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
